seq_sll64: RTL and testbench



---
 rtl/seq_sll64.sv | 96 +++++++++
 tb/tb_seq_sll64.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_sll64.sv
// Sequential 64-bit logical left shifter: zero-extends a 32-bit operand and shifts it
// left by b[4:0], STEP bits per cycle, publishing the result only when the operation completes.
module seq_sll64 #(
    parameter int unsigned STEP = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] res_high,
    output logic [31:0] res_low
);

    if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : gen_bad_step
        $error("seq_sll64: STEP must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [4:0] StepAmt = 5'(STEP);

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic [4:0]  shift_k;
    logic [4:0]  cnt_rem;

    // Only the low five bits of the shift amount are meaningful.
    logic unused_b_high;
    assign unused_b_high = ^b[31:5];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        shift_k = (cnt_q < StepAmt) ? cnt_q : StepAmt;
        cnt_rem = cnt_q - shift_k;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = {32'h0, a};
                    cnt_d   = b[4:0];
                    state_d = (b[4:0] != 5'd0) ? StShift : StDone;
                end
            end
            StShift: begin
                acc_d = acc_q << shift_k;
                cnt_d = cnt_rem;
                if (cnt_rem == 5'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Results move only on the edge entering DONE, so partial shifts never leak out.
        if (state_d == StDone && state_q != StDone) begin
            res_d = acc_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            acc_q   <= 64'h0;
            cnt_q   <= 5'd0;
            res_q   <= 64'h0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign res_high = res_q[63:32];
    assign res_low  = res_q[31:0];

endmodule

// File: tb/tb_seq_sll64.sv
// Directed self-checking bench for seq_sll64; a STEP=1 and a STEP=4 instance share stimulus.
module tb_seq_sll64;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy, done;
    logic [31:0] res_high, res_low;
    logic        busy4, done4;
    logic [31:0] res_high4, res_low4;

    int n_checks;
    int n_fail;

    seq_sll64 #(.STEP(1)) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .res_high (res_high),
        .res_low  (res_low)
    );

    seq_sll64 #(.STEP(4)) u_dut4 (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy4),
        .done     (done4),
        .res_high (res_high4),
        .res_low  (res_low4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulses start for one edge, scrambles a/b afterwards, then observes 40 falling edges.
    // Index 0 is the falling edge right after the start edge; -1 means no done seen.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          output int lat, output int lat4, output int busy_cnt,
                          output int done_cnt, output logic [63:0] res_early);
        @(negedge clock);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(negedge clock);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat = -1; lat4 = -1; busy_cnt = 0; done_cnt = 0;
        res_early = {res_high, res_low};
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = i;
            end
            if (done4 && lat4 < 0) lat4 = i;
            if (i < 39) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        a       = 32'h0000_0005;
        b       = 32'h0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags busy/done=%b%b required 00", busy, done);
        end
        n_checks++;
        if ({res_high, res_low} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_res got %h required 0", {res_high, res_low});
        end
        // First edge with reset released must accept the pending start (shift 0 -> DONE).
        reset_n = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b11) begin
            n_fail++;
            $display("FAIL first_start busy/done=%b%b required 11", busy, done);
        end
        n_checks++;
        if ({res_high, res_low} !== 64'h0000_0000_0000_0005) begin
            n_fail++;
            $display("FAIL first_start_res got %h required 5", {res_high, res_low});
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic();
        int lat, lat4, bc, dc;
        logic [63:0] early;
        run_op(32'h8000_0001, 32'h1, lat, lat4, bc, dc, early);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL basic_latency got %0d required 1", lat);
        end
        n_checks++;
        if ({res_high, res_low} !== 64'h0000_0001_0000_0002) begin
            n_fail++;
            $display("FAIL basic_res got %h required 0000000100000002", {res_high, res_low});
        end
        n_checks++;
        if (early !== 64'h0000_0000_0000_0005) begin
            n_fail++;
            $display("FAIL basic_res_hold got %h required 5", early);
        end
    endtask

    task automatic test_zero_shift();
        int lat, lat4, bc, dc;
        logic [63:0] early;
        run_op(32'hDEAD_BEEF, 32'h0, lat, lat4, bc, dc, early);
        n_checks++;
        if (lat !== 0 || bc !== 1) begin
            n_fail++;
            $display("FAIL zero_latency got lat=%0d busy=%0d required lat=0 busy=1", lat, bc);
        end
        n_checks++;
        if ({res_high, res_low} !== 64'h0000_0000_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL zero_res got %h required 00000000deadbeef", {res_high, res_low});
        end
    endtask

    task automatic test_max_shift();
        int lat, lat4, bc, dc;
        logic [63:0] early;
        run_op(32'hFFFF_FFFF, 32'd31, lat, lat4, bc, dc, early);
        n_checks++;
        if (lat !== 31 || bc !== 32 || dc !== 1) begin
            n_fail++;
            $display("FAIL max_timing got lat=%0d busy=%0d done=%0d required 31/32/1",
                     lat, bc, dc);
        end
        n_checks++;
        if ({res_high, res_low} !== 64'h7FFF_FFFF_8000_0000) begin
            n_fail++;
            $display("FAIL max_res got %h required 7fffffff80000000", {res_high, res_low});
        end
        n_checks++;
        if (lat4 !== 8) begin
            n_fail++;
            $display("FAIL max_latency_step4 got %0d required 8", lat4);
        end
    endtask

    task automatic test_shift5();
        int lat, lat4, bc, dc;
        logic [63:0] early;
        run_op(32'h1, 32'h0000_0025, lat, lat4, bc, dc, early);
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL shift5_latency got %0d required 5", lat);
        end
        n_checks++;
        if (lat4 !== 2) begin
            n_fail++;
            $display("FAIL shift5_latency_step4 got %0d required 2", lat4);
        end
        n_checks++;
        if ({res_high, res_low} !== 64'h20 || {res_high4, res_low4} !== 64'h20) begin
            n_fail++;
            $display("FAIL shift5_res got %h / %h required 20", {res_high, res_low},
                     {res_high4, res_low4});
        end
    endtask

    // Start ignored while busy, then the earliest back-to-back start after DONE.
    task automatic test_back_to_back();
        int lat;
        @(negedge clock);
        start = 1'b1;
        a     = 32'h0000_0123;
        b     = 32'd10;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1;
        a     = 32'h0000_FFFF;
        b     = 32'd3;
        @(negedge clock);
        start = 1'b0;
        lat = -1;
        for (int i = 4; i < 45; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clock);
        end
        n_checks++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL ignore_latency got %0d required 10", lat);
        end
        n_checks++;
        if ({res_high, res_low} !== 64'h0000_0000_0004_8C00) begin
            n_fail++;
            $display("FAIL ignore_res got %h required 48c00", {res_high, res_low});
        end
        // Start raised during DONE is ignored; held through IDLE it is accepted.
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd2;
        @(negedge clock);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_idle busy/done=%b%b required 00", busy, done);
        end
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_accept busy/done=%b%b required 10", busy, done);
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (done !== 1'b1 || {res_high, res_low} !== 64'd12) begin
            n_fail++;
            $display("FAIL b2b_res done=%b res=%h required 1/c", done, {res_high, res_low});
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_abort();
        int dc;
        @(negedge clock);
        start = 1'b1;
        a     = 32'h0000_0001;
        b     = 32'd20;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy, done} !== 2'b00 || {res_high, res_low} !== 64'h0) begin
            n_fail++;
            $display("FAIL abort_state busy/done=%b%b res=%h required 00/0", busy, done,
                     {res_high, res_low});
        end
        reset_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) dc++;
            @(negedge clock);
        end
        n_checks++;
        if (dc !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done got %0d active cycles required 0", dc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        test_reset();
        test_basic();
        test_zero_shift();
        test_max_shift();
        test_shift5();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
